tile_sequencer: RTL

TILE_SEQUENCER -- requirements
Module: tile_sequencer

---
 rtl/tile_sequencer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/tile_sequencer.sv
// Tile sequencer: walks a GEMM job as (nt outer, kt inner) tiles and issues one command per tile.
// Optional build macro TILE_SEQ_PERF_EN adds a busy-cycle counter at CSR 0x40.
module tile_sequencer #(
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int ADDR_WIDTH           = 10,
    parameter int CSR_ADDR_WIDTH       = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [CSR_ADDR_WIDTH-1:0]             csr_addr,
    input  logic                                  csr_wr_en,
    input  logic [31:0]                           csr_wr_data,
    input  logic                                  csr_rd_en,
    output logic [31:0]                           csr_rd_data,
    output logic                                  tile_cmd_valid,
    input  logic                                  tile_cmd_ready,
    output logic [ADDR_WIDTH-1:0]                 tile_addr_a,
    output logic [ADDR_WIDTH-1:0]                 tile_addr_b,
    output logic [ADDR_WIDTH-1:0]                 tile_addr_d,
    output logic [$clog2(SYSTOLIC_ARRAY_WIDTH):0] tile_k_len,
    output logic [$clog2(SYSTOLIC_ARRAY_WIDTH):0] tile_n_len,
    output logic [15:0]                           tile_m_len,
    output logic                                  tile_accum,
    output logic                                  tile_last_k,
    input  logic                                  tile_done,
    output logic                                  irq
);
    localparam int W     = SYSTOLIC_ARRAY_WIDTH;
    localparam int LOG2W = $clog2(W);
    localparam int KLW   = LOG2W + 1;
    localparam int AW    = ADDR_WIDTH;

    localparam logic [CSR_ADDR_WIDTH-1:0] A_CONTROL  = CSR_ADDR_WIDTH'(8'h00);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_STATUS   = CSR_ADDR_WIDTH'(8'h04);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_DIM_M    = CSR_ADDR_WIDTH'(8'h10);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_DIM_K    = CSR_ADDR_WIDTH'(8'h14);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_DIM_N    = CSR_ADDR_WIDTH'(8'h18);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_BASE_A   = CSR_ADDR_WIDTH'(8'h20);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_BASE_B   = CSR_ADDR_WIDTH'(8'h24);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_BASE_D   = CSR_ADDR_WIDTH'(8'h28);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_STRIDE_A = CSR_ADDR_WIDTH'(8'h2C);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_STRIDE_D = CSR_ADDR_WIDTH'(8'h30);
`ifdef TILE_SEQ_PERF_EN
    localparam logic [CSR_ADDR_WIDTH-1:0] A_PERF     = CSR_ADDR_WIDTH'(8'h40);
`endif

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, NEXT, DONE} state_t;
    state_t state, state_next;

    logic [15:0]   dim_m, dim_k, dim_n;
    logic [AW-1:0] base_a, base_b, base_d, stride_a, stride_d;
    logic          done_r, err_r, abort_pend;

    logic [15:0]      m_len_l, tiles_k, tiles_n, kt, nt;
    logic [LOG2W-1:0] k_rem, n_rem;
    logic [AW-1:0]    a_off, b_off, d_off;

    logic        busy, wr_ctrl, start_go, abort_req, abort_any;
    logic        last_k, last_n, dim_zero, err_set;
    logic [16:0] k_sum, n_sum;
    logic        unused_ok;

    assign unused_ok = &{1'b0, csr_rd_en, csr_wr_data};

    assign busy      = (state != IDLE);
    assign wr_ctrl   = csr_wr_en && (csr_addr == A_CONTROL);
    assign start_go  = wr_ctrl && csr_wr_data[0] && (state == IDLE);
    assign abort_req = wr_ctrl && csr_wr_data[1] && (state != IDLE) && (state != DONE);
    assign abort_any = abort_pend || abort_req;
    assign last_k    = (kt == tiles_k - 16'd1);
    assign last_n    = (nt == tiles_n - 16'd1);
    assign dim_zero  = (m_len_l == 16'd0) || (tiles_k == 16'd0) || (tiles_n == 16'd0);
    assign k_sum     = {1'b0, dim_k} + 17'(W - 1);
    assign n_sum     = {1'b0, dim_n} + 17'(W - 1);

    // An abort that lands in NEXT stops before the following tile is issued.
    assign err_set = ((state == CHECK) && dim_zero)
                  || ((state == WAIT) && tile_done && abort_any)
                  || ((state == NEXT) && abort_any);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_go) state_next = CHECK;
            CHECK:   state_next = dim_zero ? DONE : ISSUE;
            ISSUE:   if (tile_cmd_ready) state_next = WAIT;
            WAIT:    if (tile_done) state_next = abort_any ? DONE : NEXT;
            NEXT:    state_next = (abort_any || (last_k && last_n)) ? DONE : ISSUE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tile_cmd_valid = 1'b0;
        tile_addr_a    = '0;
        tile_addr_b    = '0;
        tile_addr_d    = '0;
        tile_k_len     = '0;
        tile_n_len     = '0;
        tile_m_len     = '0;
        tile_accum     = 1'b0;
        tile_last_k    = 1'b0;
        irq            = (state == DONE);
        if (state == ISSUE) begin
            tile_cmd_valid = 1'b1;
            tile_addr_a    = base_a + a_off;
            tile_addr_b    = base_b + b_off;
            tile_addr_d    = base_d + d_off;
            tile_k_len     = (last_k && k_rem != '0) ? {1'b0, k_rem} : KLW'(W);
            tile_n_len     = (last_n && n_rem != '0) ? {1'b0, n_rem} : KLW'(W);
            tile_m_len     = m_len_l;
            tile_accum     = (kt != 16'd0);
            tile_last_k    = last_k;
        end
    end

    // Host-visible registers and sticky status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dim_m      <= '0;
            dim_k      <= '0;
            dim_n      <= '0;
            base_a     <= '0;
            base_b     <= '0;
            base_d     <= '0;
            stride_a   <= '0;
            stride_d   <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            if (csr_wr_en) begin
                case (csr_addr)
                    A_DIM_M:    dim_m    <= csr_wr_data[15:0];
                    A_DIM_K:    dim_k    <= csr_wr_data[15:0];
                    A_DIM_N:    dim_n    <= csr_wr_data[15:0];
                    A_BASE_A:   base_a   <= csr_wr_data[AW-1:0];
                    A_BASE_B:   base_b   <= csr_wr_data[AW-1:0];
                    A_BASE_D:   base_d   <= csr_wr_data[AW-1:0];
                    A_STRIDE_A: stride_a <= csr_wr_data[AW-1:0];
                    A_STRIDE_D: stride_d <= csr_wr_data[AW-1:0];
                    A_STATUS: begin
                        if (csr_wr_data[1]) done_r <= 1'b0;
                        if (csr_wr_data[2]) err_r  <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (start_go) begin
                done_r <= 1'b0;
                err_r  <= 1'b0;
            end
            if (state == DONE) done_r <= 1'b1;
            if (err_set)       err_r  <= 1'b1;
            if (state == IDLE || state == DONE) abort_pend <= 1'b0;
            else if (abort_req)                 abort_pend <= 1'b1;
        end
    end

    // Job snapshot and tile walk; offsets accumulate so no multipliers are needed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_len_l <= '0;
            tiles_k <= '0;
            tiles_n <= '0;
            k_rem   <= '0;
            n_rem   <= '0;
            kt      <= '0;
            nt      <= '0;
            a_off   <= '0;
            b_off   <= '0;
            d_off   <= '0;
        end else if (start_go) begin
            m_len_l <= dim_m;
            tiles_k <= 16'(k_sum >> LOG2W);
            tiles_n <= 16'(n_sum >> LOG2W);
            k_rem   <= dim_k[LOG2W-1:0];
            n_rem   <= dim_n[LOG2W-1:0];
            kt      <= '0;
            nt      <= '0;
            a_off   <= '0;
            b_off   <= '0;
            d_off   <= '0;
        end else if (state == NEXT && state_next == ISSUE) begin
            b_off <= b_off + AW'(W);
            if (last_k) begin
                kt    <= '0;
                a_off <= '0;
                nt    <= nt + 16'd1;
                d_off <= d_off + stride_d;
            end else begin
                kt    <= kt + 16'd1;
                a_off <= a_off + stride_a;
            end
        end
    end

`ifdef TILE_SEQ_PERF_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)        cycle_cnt <= '0;
        else if (start_go) cycle_cnt <= '0;
        else if (busy)     cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

    always_comb begin
        csr_rd_data = 32'hDEADBEEF;
        case (csr_addr)
            A_CONTROL:  csr_rd_data = 32'h0;
            A_STATUS:   csr_rd_data = {29'b0, err_r, done_r, busy};
            A_DIM_M:    csr_rd_data = {16'b0, dim_m};
            A_DIM_K:    csr_rd_data = {16'b0, dim_k};
            A_DIM_N:    csr_rd_data = {16'b0, dim_n};
            A_BASE_A:   csr_rd_data = 32'(base_a);
            A_BASE_B:   csr_rd_data = 32'(base_b);
            A_BASE_D:   csr_rd_data = 32'(base_d);
            A_STRIDE_A: csr_rd_data = 32'(stride_a);
            A_STRIDE_D: csr_rd_data = 32'(stride_d);
`ifdef TILE_SEQ_PERF_EN
            A_PERF:     csr_rd_data = cycle_cnt;
`endif
            default:    csr_rd_data = 32'hDEADBEEF;
        endcase
    end
endmodule
